// File: rtl/approx_mult_error_monitor.sv
// approx_mult_error_monitor: window accuracy stats (ER/MED/WCE) of an approx multiplier.
// Optional signed error sum output sum_err is enabled by defining ERR_SIGNED_EN.
module approx_mult_error_monitor #(
  parameter int W = 4,
  parameter int NSAMP = 256,
  parameter int SUM_W = 16,
  localparam int CW = $clog2(NSAMP + 1),
  localparam int P = 2 * W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [P-1:0] in_approx,
  output logic busy,
  output logic done,
  output logic [CW-1:0] sample_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [P-1:0] max_ed,
  output logic [W-1:0] max_a,
  output logic [W-1:0] max_b
`ifdef ERR_SIGNED_EN
  ,
  output logic signed [SUM_W:0] sum_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CW-1:0] NS = CW'(NSAMP);
  localparam logic [CW-1:0] NS1 = CW'(NSAMP - 1);
  localparam int AW = ((SUM_W > P) ? SUM_W : P) + 1;
  localparam logic [AW-1:0] SUM_MAX = (AW'(1) << SUM_W) - AW'(1);

  state_t state;
  state_t state_nx;

  logic accept;
  logic clr;
  logic last;

  logic v1;
  logic v2;
  logic [P-1:0] e1;
  logic [P-1:0] x1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic [P-1:0] ed2;
  logic [W-1:0] a2;
  logic [W-1:0] b2;

  logic [P-1:0] prod;
  logic [P-1:0] ed_c;
  logic [AW-1:0] sum_nx;
  logic [SUM_W-1:0] sum_sat;

  assign accept = in_valid & in_ready;
  assign clr = (state == IDLE) & start;
  assign last = accept & (sample_cnt == NS1);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: if (last) state_nx = DRAIN;
      DRAIN: if (!v1 && !v2) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    in_ready = 1'b0;
    unique case (state)
      RUN: begin
        busy = 1'b1;
        in_ready = (sample_cnt < NS);
      end
      DRAIN: busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign prod = P'(in_a) * P'(in_b);
  assign ed_c = (e1 >= x1) ? (e1 - x1) : (x1 - e1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      e1 <= '0;
      x1 <= '0;
      a1 <= '0;
      b1 <= '0;
      v2 <= 1'b0;
      ed2 <= '0;
      a2 <= '0;
      b2 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        e1 <= prod;
        x1 <= in_approx;
        a1 <= in_a;
        b1 <= in_b;
      end
      v2 <= v1;
      if (v1) begin
        ed2 <= ed_c;
        a2 <= a1;
        b2 <= b1;
      end
    end
  end

  assign sum_nx = AW'(sum_ed) + AW'(ed2);
  assign sum_sat = (sum_nx > SUM_MAX) ? {SUM_W{1'b1}} : sum_nx[SUM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt <= '0;
      sum_ed <= '0;
      max_ed <= '0;
      max_a <= '0;
      max_b <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      err_cnt <= '0;
      sum_ed <= '0;
      max_ed <= '0;
      max_a <= '0;
      max_b <= '0;
    end else begin
      if (accept) sample_cnt <= sample_cnt + CW'(1);
      if (v2) begin
        err_cnt <= err_cnt + CW'(ed2 != '0);
        sum_ed <= sum_sat;
        // strict compare: ties keep the earliest sample
        if (ed2 > max_ed) begin
          max_ed <= ed2;
          max_a <= a2;
          max_b <= b2;
        end
      end
    end
  end

`ifdef ERR_SIGNED_EN
  localparam int SW = ((SUM_W > P) ? SUM_W : P) + 2;
  localparam logic signed [SW-1:0] SE_MAX = (SW'(1) << SUM_W) - SW'(1);
  localparam logic signed [SW-1:0] SE_MIN = -SE_MAX;

  logic signed [P:0] sd_c;
  logic signed [P:0] sd2;
  logic signed [SW-1:0] se_nx;
  logic signed [SUM_W:0] se_sat;

  assign sd_c = $signed({1'b0, x1}) - $signed({1'b0, e1});
  assign se_nx = SW'(sum_err) + SW'(sd2);

  always_comb begin
    se_sat = se_nx[SUM_W:0];
    if (se_nx > SE_MAX) se_sat = SE_MAX[SUM_W:0];
    else if (se_nx < SE_MIN) se_sat = SE_MIN[SUM_W:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd2 <= '0;
      sum_err <= '0;
    end else begin
      if (v1) sd2 <= sd_c;
      if (clr) sum_err <= '0;
      else if (v2) sum_err <= se_sat;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// tb_approx_mult_error_monitor: directed table-driven bench for approx_mult_error_monitor.
// Define ERR_SIGNED_EN to also check sum_err.
module tb_approx_mult_error_monitor;

  logic clk = 1'b0;
  logic rst;
  logic valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] ap;
  logic start;
  logic start5;
  logic startd;

  logic rdy, busy, done;
  logic [2:0] scnt, ecnt;
  logic [15:0] sed;
  logic [7:0] med;
  logic [3:0] ma, mb;

  logic rdy5, busy5, done5;
  logic [1:0] scnt5, ecnt5;
  logic [3:0] sed5;
  logic [7:0] med5;
  logic [3:0] ma5, mb5;

  logic rdyd, busyd, doned;
  logic [8:0] scntd, ecntd;
  logic [15:0] sedd;
  logic [7:0] medd;
  logic [3:0] mad, mbd;

`ifdef ERR_SIGNED_EN
  logic signed [16:0] serr;
  logic signed [4:0] serr5;
  logic signed [16:0] serrd;
`endif

  int nchk = 0;
  int npass = 0;
  int dcnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done) dcnt <= dcnt + 1;

  approx_mult_error_monitor #(.W(4), .NSAMP(4), .SUM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(valid), .in_ready(rdy),
    .in_a(a), .in_b(b), .in_approx(ap),
    .busy(busy), .done(done),
    .sample_cnt(scnt), .err_cnt(ecnt), .sum_ed(sed),
    .max_ed(med), .max_a(ma), .max_b(mb)
`ifdef ERR_SIGNED_EN
    , .sum_err(serr)
`endif
  );

  approx_mult_error_monitor #(.W(4), .NSAMP(3), .SUM_W(4)) dut5 (
    .clk(clk), .rst(rst), .start(start5),
    .in_valid(valid), .in_ready(rdy5),
    .in_a(a), .in_b(b), .in_approx(ap),
    .busy(busy5), .done(done5),
    .sample_cnt(scnt5), .err_cnt(ecnt5), .sum_ed(sed5),
    .max_ed(med5), .max_a(ma5), .max_b(mb5)
`ifdef ERR_SIGNED_EN
    , .sum_err(serr5)
`endif
  );

  approx_mult_error_monitor dutd (
    .clk(clk), .rst(rst), .start(startd),
    .in_valid(valid), .in_ready(rdyd),
    .in_a(a), .in_b(b), .in_approx(ap),
    .busy(busyd), .done(doned),
    .sample_cnt(scntd), .err_cnt(ecntd), .sum_ed(sedd),
    .max_ed(medd), .max_a(mad), .max_b(mbd)
`ifdef ERR_SIGNED_EN
    , .sum_err(serrd)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] ap;
    int err;
    int sum;
    int mx;
    int ma;
    int mb;
    int se;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  initial begin
    int acc, last_t, done_t, viol;

    // a, b, approx, then cumulative err, sum_ed, max_ed, max_a, max_b, sum_err
    tbl[0] = '{4'd3, 4'd5, 8'd15, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{4'd3, 4'd5, 8'd12, 1, 3, 3, 3, 5, -3};
    tbl[2] = '{4'd2, 4'd2, 8'd4, 1, 3, 3, 3, 5, -3};
    tbl[3] = '{4'd7, 4'd7, 8'd40, 2, 12, 9, 7, 7, -12};
    tbl[4] = '{4'd15, 4'd15, 8'd0, 1, 225, 225, 15, 15, -225};
    tbl[5] = '{4'd15, 4'd15, 8'd255, 2, 255, 225, 15, 15, -195};
    tbl[6] = '{4'd0, 4'd0, 8'd0, 2, 255, 225, 15, 15, -195};
    tbl[7] = '{4'd4, 4'd6, 8'd20, 3, 259, 225, 15, 15, -199};
    tbl[8] = '{4'd3, 4'd5, 8'd12, 1, 3, 3, 3, 5, -3};
    tbl[9] = '{4'd2, 4'd2, 8'd7, 2, 6, 3, 3, 5, 0};
    tbl[10] = '{4'd2, 4'd3, 8'd0, 3, 12, 6, 2, 3, -6};
    tbl[11] = '{4'd1, 4'd6, 8'd0, 4, 18, 6, 2, 3, -12};

    rst = 1'b1;
    valid = 1'b0;
    a = '0;
    b = '0;
    ap = '0;
    start = 1'b0;
    start5 = 1'b0;
    startd = 1'b0;
    tick();
    tick();
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst in_ready", int'(rdy), 0);
    chk("rst sample_cnt", int'(scnt), 0);
    chk("rst err_cnt", int'(ecnt), 0);
    chk("rst sum_ed", int'(sed), 0);
    chk("rst max_ed", int'(med), 0);
    chk("rst max_a", int'(ma), 0);
    chk("rst max_b", int'(mb), 0);
    rst = 1'b0;
    tick();

    // abort a running window with an async reset pulse
    startd = 1'b1;
    tick();
    startd = 1'b0;
    valid = 1'b1;
    a = 4'd7;
    b = 4'd7;
    ap = 8'd40;
    for (int k = 0; k < 5; k++) tick();
    valid = 1'b0;
    chk("abort pre sample_cnt", int'(scntd), 5);
    tick();
    chk("abort pre err_cnt", int'(ecntd), 4);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    chk("abort busy", int'(busyd), 0);
    chk("abort in_ready", int'(rdyd), 0);
    chk("abort sample_cnt", int'(scntd), 0);
    chk("abort err_cnt", int'(ecntd), 0);
    chk("abort sum_ed", int'(sedd), 0);
    chk("abort max_ed", int'(medd), 0);
    chk("abort max_a", int'(mad), 0);
    chk("abort max_b", int'(mbd), 0);
    tick();
    tick();
    chk("abort late err_cnt", int'(ecntd), 0);

    // three windows of four samples, one sample at a time
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("w%0d busy", i / 4), int'(busy), 1);
        chk($sformatf("w%0d clr cnt", i / 4), int'(scnt), 0);
        chk($sformatf("w%0d clr sum", i / 4), int'(sed), 0);
        chk($sformatf("w%0d clr max", i / 4), int'(med), 0);
`ifdef ERR_SIGNED_EN
        chk($sformatf("w%0d clr sum_err", i / 4), int'(serr), 0);
`endif
      end
      chk($sformatf("in_ready[%0d]", i), int'(rdy), 1);
      valid = 1'b1;
      a = tbl[i].a;
      b = tbl[i].b;
      ap = tbl[i].ap;
      tick();
      valid = 1'b0;
      a = 4'hx;
      b = 4'hx;
      tick();
      tick();
      chk($sformatf("sample_cnt[%0d]", i), int'(scnt), i % 4 + 1);
      chk($sformatf("err_cnt[%0d]", i), int'(ecnt), tbl[i].err);
      chk($sformatf("sum_ed[%0d]", i), int'(sed), tbl[i].sum);
      chk($sformatf("max_ed[%0d]", i), int'(med), tbl[i].mx);
      chk($sformatf("max_a[%0d]", i), int'(ma), tbl[i].ma);
      chk($sformatf("max_b[%0d]", i), int'(mb), tbl[i].mb);
`ifdef ERR_SIGNED_EN
      chk($sformatf("sum_err[%0d]", i), int'(serr), tbl[i].se);
`endif
      if (i % 4 == 3) begin
        tick();
        chk($sformatf("done[%0d]", i), int'(done), 1);
        chk($sformatf("done busy[%0d]", i), int'(busy), 0);
        chk($sformatf("done rdy[%0d]", i), int'(rdy), 0);
        if (i == 3) start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("post done[%0d]", i), int'(done), 0);
        chk($sformatf("post busy[%0d]", i), int'(busy), 0);
        chk($sformatf("hold cnt[%0d]", i), int'(scnt), 4);
        chk($sformatf("done pulses[%0d]", i), dcnt, i / 4 + 1);
      end
    end

    // in_valid toggling every cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 4'd1;
    b = 4'd1;
    ap = 8'd1;
    acc = 0;
    last_t = -1;
    done_t = -1;
    viol = 0;
    for (int t = 0; t < 20; t++) begin
      if (done && done_t < 0) done_t = t;
      valid = (t % 2 == 0);
      if (acc == 4 && rdy) viol++;
      if (valid && rdy) begin
        acc++;
        last_t = t;
      end
      tick();
    end
    valid = 1'b0;
    chk("toggle accepts", acc, 4);
    chk("toggle ready after last", viol, 0);
    chk("toggle done latency", done_t - last_t, 4);
    chk("toggle sample_cnt", int'(scnt), 4);
    chk("toggle err_cnt", int'(ecnt), 0);
    chk("toggle done pulses", dcnt, 4);

    // saturating ED sum on a narrow accumulator
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    valid = 1'b1;
    a = 4'd7;
    b = 4'd7;
    ap = 8'd40;
    for (int k = 0; k < 3; k++) tick();
    valid = 1'b0;
    chk("sat in_ready", int'(rdy5), 0);
    tick();
    tick();
    chk("sat sample_cnt", int'(scnt5), 3);
    chk("sat err_cnt", int'(ecnt5), 3);
    chk("sat sum_ed", int'(sed5), 15);
    chk("sat max_ed", int'(med5), 9);
`ifdef ERR_SIGNED_EN
    chk("sat sum_err", int'(serr5), -15);
`endif
    tick();
    chk("sat done", int'(done5), 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
